// File: rtl/div_round_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : div_round_seq_if
// Description : Operand/result handshake bundle for div_round_seq.
//               master = producer/consumer side, slave = rounding sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface div_round_seq_if #(
    parameter int WIDTH = 28
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     q;
    logic [WIDTH-1:0]     d;
    logic [2*WIDTH-1:0]   n_aligned;
    logic                 mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     y;
    logic                 rem_pos;
    logic                 rem_neg;
    logic                 inexact;
    logic                 wrap;

    modport master (
        output in_valid, q, d, n_aligned, mode, out_ready,
        input  in_ready, out_valid, y, rem_pos, rem_neg, inexact, wrap
    );

    modport slave (
        input  in_valid, q, d, n_aligned, mode, out_ready,
        output in_ready, out_valid, y, rem_pos, rem_neg, inexact, wrap
    );
endinterface
`default_nettype wire

// File: rtl/div_round_seq.sv
`default_nettype none
// ============================================================================
// Module      : div_round_seq
// Description : Final rounding sequencer of the divider. Back-multiplies the
//               unrounded quotient with a serial shift-add multiplier, derives
//               the remainder sign and rounds to nearest or toward zero.
//               Optional macro ROUND_TIE_EVEN_EN: exact ties round to even.
// Revision    : 1.0 - initial release
// ============================================================================
module div_round_seq #(
    parameter int WIDTH = 28,
    parameter int ULP   = 4
) (
    input  logic          clk,
    input  logic          reset,
    div_round_seq_if.slave bus
);

    localparam int                 CNT_W      = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   LSB        = WIDTH'(1) << ULP;
    localparam logic [WIDTH-1:0]   GUARD_MASK = LSB - WIDTH'(1);
    // Guard bits strictly below the half-ULP bit; empty when ULP == 1.
    localparam logic [WIDTH-1:0]   LOW_MASK   = (WIDTH'(1) << (ULP - 1)) - WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        EVAL = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [WIDTH-1:0]     d_q, d_d;
    logic [2*WIDTH-1:0]   n_q, n_d;
    logic                 mode_q, mode_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     y_q, y_d;
    logic                 rem_pos_q, rem_pos_d;
    logic                 rem_neg_q, rem_neg_d;
    logic                 inexact_q, inexact_d;
    logic                 wrap_q, wrap_d;

    logic [2*WIDTH:0]     w_rem;
    logic                 w_rem_zero;
    logic                 w_rem_neg;
    logic                 w_rem_pos;
    logic [WIDTH-1:0]     w_trunc;
    logic [WIDTH:0]       w_inc;
    logic [WIDTH:0]       w_dec;
    logic                 w_round_up;
    logic                 w_round_dn;

    // Remainder sign and rounding candidates from the latched operands.
    always_comb begin
        w_rem      = {1'b0, n_q} - {1'b0, acc_q};
        w_rem_zero = (w_rem == '0);
        w_rem_neg  = w_rem[2*WIDTH];
        w_rem_pos  = !w_rem_neg && !w_rem_zero;
        w_trunc    = q_q & ~GUARD_MASK;
        w_inc      = {1'b0, w_trunc} + {1'b0, LSB};
        w_dec      = {1'b0, w_trunc} - {1'b0, LSB};
`ifdef ROUND_TIE_EVEN_EN
        // Exact half-way case: only the half bit set and zero remainder;
        // bump when the kept LSB is odd.
        w_round_up = !mode_q && q_q[ULP-1] &&
                     (w_rem_pos ||
                      (w_rem_zero && ((q_q & LOW_MASK) == '0) && q_q[ULP]));
`else
        w_round_up = !mode_q && q_q[ULP-1] && w_rem_pos;
`endif
        w_round_dn = mode_q && !q_q[ULP-1] && w_rem_neg;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            q_q       <= '0;
            d_q       <= '0;
            n_q       <= '0;
            mode_q    <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            y_q       <= '0;
            rem_pos_q <= 1'b0;
            rem_neg_q <= 1'b0;
            inexact_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            d_q       <= d_d;
            n_q       <= n_d;
            mode_q    <= mode_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            y_q       <= y_d;
            rem_pos_q <= rem_pos_d;
            rem_neg_q <= rem_neg_d;
            inexact_q <= inexact_d;
            wrap_q    <= wrap_d;
        end
    end

    // Next-state: accept, serial multiply LSB first, evaluate, hold result.
    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        d_d       = d_q;
        n_d       = n_q;
        mode_d    = mode_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        y_d       = y_q;
        rem_pos_d = rem_pos_q;
        rem_neg_d = rem_neg_q;
        inexact_d = inexact_q;
        wrap_d    = wrap_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    q_d     = bus.q;
                    d_d     = bus.d;
                    n_d     = bus.n_aligned;
                    mode_d  = bus.mode;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                if (q_q[cnt_q]) begin
                    acc_d = acc_q + ({{WIDTH{1'b0}}, d_q} << cnt_q);
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = EVAL;
                end
            end
            EVAL: begin
                rem_pos_d = w_rem_pos;
                rem_neg_d = w_rem_neg;
                inexact_d = !w_rem_zero || ((q_q & GUARD_MASK) != '0);
                if (w_round_up) begin
                    y_d    = w_inc[WIDTH-1:0];
                    wrap_d = w_inc[WIDTH];
                end else if (w_round_dn) begin
                    y_d    = w_dec[WIDTH-1:0];
                    wrap_d = w_dec[WIDTH];
                end else begin
                    y_d    = w_trunc;
                    wrap_d = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.y         = y_q;
    assign bus.rem_pos   = rem_pos_q;
    assign bus.rem_neg   = rem_neg_q;
    assign bus.inexact   = inexact_q;
    assign bus.wrap      = wrap_q;

endmodule
`default_nettype wire

// File: doc/div_round_seq.md
Name: div_round_seq

Overview:
- Sequencer for the divider's final rounding step.
- Accepts an unrounded quotient carrying ULP guard bits, together with the aligned dividend and the divisor.
- Computes the remainder sign by back-multiplying with an internal serial shift-add multiplier, then applies round-to-nearest or round-toward-zero.
- Sits between the quotient iteration stage and result packing; uses a valid/ready handshake on both sides.

Parameters:
- WIDTH, 28, quotient/divisor width in bits.
- ULP, 4, number of guard bits below the result LSB; legal range 1..WIDTH-1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand.
- q  in  WIDTH  unrounded quotient; bits [ULP-1:0] are guard bits.
- d  in  WIDTH  divisor.
- n_aligned  in  2*WIDTH  dividend pre-aligned to the scale of q*d.
- mode  in  1  rounding mode; 0 = nearest, 1 = toward zero.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- y  out  WIDTH  rounded result; bits [ULP-1:0] always 0.
- rem_pos  out  1  remainder > 0.
- rem_neg  out  1  remainder < 0.
- inexact  out  1  remainder != 0 or q[ULP-1:0] != 0.
- wrap  out  1  rounding increment/decrement wrapped modulo 2^WIDTH.

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0; y, rem_pos, rem_neg, inexact, wrap all 0.
- States: IDLE, MUL, EVAL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch q, d, n_aligned, mode; clear the 2*WIDTH accumulator; set counter=0; go to MUL.
- MUL:
  - One cycle per quotient bit, LSB first.
  - If q_latched[cnt]=1: acc += d << cnt.
  - After WIDTH cycles (cnt=WIDTH-1 processed), go to EVAL.
  - acc never overflows 2*WIDTH bits.
- EVAL (1 cycle):
  - rem = {0,n_aligned} - {0,acc}, 2*WIDTH+1-bit signed.
  - rem_pos = (rem>0); rem_neg = (rem<0); both 0 when rem==0.
  - trunc = {q[WIDTH-1:ULP], ULP'b0}; lsb = 1<<ULP.
  - mode 0: y = trunc+lsb if q[ULP-1]=1 and rem_pos; else y = trunc.
  - mode 1: y = trunc-lsb if q[ULP-1]=0 and rem_neg; else y = trunc.
  - wrap=1 if the add carries out or the subtract borrows; y keeps the wrapped value.
  - Register all outputs, then go to DONE.
- DONE:
  - out_valid=1; y and flags held stable.
  - On out_ready: go to IDLE. out_valid deasserts next cycle, in_ready reasserts next cycle.
- Latency: handshake at edge k; MUL occupies k+1..k+WIDTH; EVAL at k+WIDTH+1; out_valid high from cycle k+WIDTH+2. Minimum initiation interval is WIDTH+3 cycles.
- Backpressure:
  - in_ready=0 in every state except IDLE.
  - No new operand is accepted while a result is pending, including the cycle in which out_ready is high.
- Input changes outside the accept cycle are ignored; operands are fully latched.
- Reset in any state: return to IDLE next cycle, discard the pending operand, restore reset values.
- Tie (rem==0, q[ULP-1]=1, mode 0): truncate, unless the optional feature is enabled.

Optional Feature:
- Macro ROUND_TIE_EVEN_EN.
- Defined: in mode 0, when rem==0, q[ULP-1]=1 and q[ULP-2:0]==0 (ULP=1: no lower-bit condition), round up if trunc[ULP]=1 (odd), else truncate. wrap is set as for any increment.
- Undefined: ties truncate as above. No extra logic is generated.

Test Plan (WIDTH=8, ULP=2, lsb=4):
- Nearest, round up: mode=0, q=0x0A, d=3, n_aligned=31 (rem=+1) -> y=0x0C, rem_pos=1, inexact=1, out_valid 10 cycles after accept.
- Toward zero, round down: mode=1, q=0x09, d=5, n_aligned=44 (rem=-1) -> y=0x04, rem_neg=1, wrap=0.
- Tie: mode=0, q=0x0E, d=3, n_aligned=42 (rem=0) -> y=0x0C without ROUND_TIE_EVEN_EN; y=0x10 with it; rem_pos=rem_neg=0.
- Wrap: mode=0, q=0xFE, d=1, n_aligned=0xFF -> y=0x00, wrap=1; mode=1, q=0x01, d=1, n_aligned=0 -> y=0xFC, wrap=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> y/flags stable, in_ready=0, a second in_valid is not taken; raise out_ready -> in_ready=1 next cycle, second operand accepted.
- Reset mid-op: assert reset in the 3rd MUL cycle -> next cycle in_ready=1, out_valid=0, all outputs 0; a fresh operand then produces the correct result with normal latency.
